// File: rtl/rv32i_inst_encoder.sv
// Packs decoded RV32I fields into instruction words and streams them with sequential imem addresses.
// Latency: a legal request accepted at edge t is visible on out_valid at t+1 when the buffer was empty.
// Backpressure: in_ready falls while the buffer is full or the session limit is reached; out side is valid/ready.

module enc_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      occ;
    logic             do_push;
    logic             do_pop;

    assign full     = (occ == (PW+1)'(DEPTH));
    assign empty    = (occ == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

module rv32i_inst_encoder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0100_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_INSTS  = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_inst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        fmt_ok;
    logic        imm_ok;
    logic        is_shift;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        below_max;
    logic        hits_max;
    logic [63:0] head_dat;

    // Sign-extension checks: every bit above the field must match its top bit.
    logic sext11_ok, sext12_ok, sext20_ok;
    assign sext11_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign sext12_ok = (&in_imm[31:12]) || !(|in_imm[31:12]);
    assign sext20_ok = (&in_imm[31:20]) || !(|in_imm[31:20]);
    assign is_shift  = (in_opcode == 7'b0010011) && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

    always_comb begin
        inst   = '0;
        fmt_ok = 1'b1;
        imm_ok = 1'b0;
        case (in_fmt)
            3'd0: begin
                inst   = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                imm_ok = 1'b1;
            end
            3'd1: begin
                if (is_shift) begin
                    inst   = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    imm_ok = !(|in_imm[31:5]);
                end else begin
                    inst   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    imm_ok = sext11_ok;
                end
            end
            3'd2: begin
                inst   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                imm_ok = sext11_ok;
            end
            3'd3: begin
                inst   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
                imm_ok = sext12_ok && !in_imm[0];
            end
            3'd4: begin
                inst   = {in_imm[31:12], in_rd, in_opcode};
                imm_ok = !(|in_imm[11:0]);
            end
            3'd5: begin
                inst   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                imm_ok = sext20_ok && !in_imm[0];
            end
            default: fmt_ok = 1'b0;
        endcase
    end

    assign below_max = ({1'b0, count} < 17'(MAX_INSTS));
    assign hits_max  = (({1'b0, count} + 17'd1) == 17'(MAX_INSTS));
    assign in_ready  = (state == RUN) && !fifo_full && below_max;
    // A start pulse wins over any handshake presented in the same cycle.
    assign accept    = in_valid && in_ready && !start;
    assign push      = accept && fmt_ok && imm_ok;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready && !start;
    assign out_addr  = head_dat[63:32];
    assign out_inst  = head_dat[31:0];
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);

    enc_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (start),
        .push     (push),
        .push_dat ({addr, inst}),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (accept && (in_last || (push && hits_max))) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty) state_nxt = DONE;
            end
            default: state_nxt = state;
        endcase
        if (start) state_nxt = RUN;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= BASE_ADDR;
            count    <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state <= state_nxt;
            if (start) begin
                addr     <= BASE_ADDR;
                count    <= '0;
                err      <= 1'b0;
                err_code <= 2'b00;
            end else if (push) begin
                addr  <= addr + 32'd4;
                count <= count + 16'd1;
            end else if (accept) begin
                err <= 1'b1;
                if (err_code == 2'b00) err_code <= fmt_ok ? 2'b01 : 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed bench for rv32i_inst_encoder: hand-computed instruction words, addresses and status flags.
module tb_rv32i_inst_encoder;
    logic        clock = 1'b0;
    logic        reset, start, in_valid, in_ready, in_last;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        out_valid, out_ready, busy, done, err;
    logic [31:0] out_addr, out_inst;
    logic [1:0]  err_code;
    logic [15:0] count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    rv32i_inst_encoder dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_inst(out_inst),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
    );

    // Called at a negedge; presents a request and returns at the negedge after it was accepted.
    task automatic send_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm, input logic last,
                            output bit timed_out);
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last; in_valid = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin timed_out = 1'b0; break; end
            @(negedge clock);
        end
        if (!timed_out) begin
            @(posedge clock);
            @(negedge clock);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at a negedge; captures the FIFO head and pops it.
    task automatic pop_head(output logic [31:0] a, output logic [31:0] w, output bit timed_out);
        timed_out = 1'b1;
        a = '0; w = '0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin timed_out = 1'b0; break; end
            @(negedge clock);
        end
        if (!timed_out) begin
            a = out_addr; w = out_inst; out_ready = 1'b1;
            @(posedge clock);
            @(negedge clock);
            out_ready = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        in_fmt = 3'd1; in_opcode = 7'b0010011; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd5;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({in_ready, out_valid, busy, done, err, err_code, count} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b done=%b err=%b code=%b cnt=%0d, need all 0",
                     in_ready, out_valid, busy, done, err, err_code, count);
        end
        in_valid = 1'b1;
        repeat (3) @(negedge clock);
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== 16'd0) begin
            tests_failed++;
            $display("FAIL idle_no_accept: got rdy=%b ov=%b cnt=%0d, need 0 0 0", in_ready, out_valid, count);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_single_i();
        bit to; logic [31:0] a, w;
        pulse_start();
        tests_run++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL start_run: got busy=%b rdy=%b, need 1 1", busy, in_ready);
        end
        send_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, to);
        tests_run++;
        if (to || out_valid !== 1'b1 || count !== 16'd1) begin
            tests_failed++; $display("FAIL i_latency: got to=%b ov=%b cnt=%0d, need 0 1 1", to, out_valid, count);
        end
        pop_head(a, w, to);
        tests_run++;
        if (to || a !== 32'h0100_0000 || w !== 32'h0050_0093) begin
            tests_failed++; $display("FAIL i_word: got to=%b addr=%h inst=%h, need 01000000 00500093", to, a, w);
        end
        @(negedge clock);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL i_done: got done=%b busy=%b, need 1 0", done, busy);
        end
    endtask

    task automatic test_branch_jump();
        bit to; logic [31:0] a, w;
        pulse_start();
        send_req(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0, to);
        send_req(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 1'b1, to);
        pop_head(a, w, to);
        tests_run++;
        if (to || a !== 32'h0100_0000 || w !== 32'h0020_8463) begin
            tests_failed++; $display("FAIL b_word: got to=%b addr=%h inst=%h, need 01000000 00208463", to, a, w);
        end
        pop_head(a, w, to);
        tests_run++;
        if (to || a !== 32'h0100_0004 || w !== 32'hFFDF_F0EF) begin
            tests_failed++; $display("FAIL j_word: got to=%b addr=%h inst=%h, need 01000004 ffdff0ef", to, a, w);
        end
    endtask

    task automatic test_full_backpressure();
        bit to; logic [31:0] a, w;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h0051_2623; exp_w[1] = 32'h1234_51B7;
        exp_w[2] = 32'h4032_5213; exp_w[3] = 32'h0083_8333;
        out_ready = 1'b0;
        pulse_start();
        send_req(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd12, 1'b0, to);
        send_req(3'd4, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, to);
        send_req(3'd1, 7'b0010011, 5'd4, 5'd4, 5'd0, 3'd5, 7'h20, 32'd3, 1'b0, to);
        send_req(3'd0, 7'b0110011, 5'd6, 5'd7, 5'd8, 3'd0, 7'd0, 32'd0, 1'b0, to);
        tests_run++;
        if (to || in_ready !== 1'b0 || count !== 16'd4 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL full_ready: got to=%b rdy=%b cnt=%0d busy=%b, need 0 0 4 1", to, in_ready, count, busy);
        end
        repeat (3) @(negedge clock);
        tests_run++;
        if (out_valid !== 1'b1 || out_addr !== 32'h0100_0000 || out_inst !== exp_w[0] || in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL hold_stable: got ov=%b addr=%h inst=%h rdy=%b, need 1 01000000 %h 0",
                                     out_valid, out_addr, out_inst, in_ready, exp_w[0]);
        end
        for (int k = 0; k < 4; k++) begin
            pop_head(a, w, to);
            tests_run++;
            if (to || a !== 32'h0100_0000 + 32'(4 * k) || w !== exp_w[k]) begin
                tests_failed++; $display("FAIL order_%0d: got to=%b addr=%h inst=%h, need %h %h",
                                         k, to, a, w, 32'h0100_0000 + 32'(4 * k), exp_w[k]);
            end
        end
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL drained_ready: got rdy=%b ov=%b, need 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_imm_range();
        bit to; logic [31:0] a, w;
        pulse_start();
        send_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, to);
        tests_run++;
        if (to || out_valid !== 1'b0 || err !== 1'b1 || err_code !== 2'b01 || count !== 16'd0) begin
            tests_failed++; $display("FAIL imm_drop: got to=%b ov=%b err=%b code=%b cnt=%0d, need 0 0 1 01 0",
                                     to, out_valid, err, err_code, count);
        end
        send_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, to);
        pop_head(a, w, to);
        tests_run++;
        if (to || a !== 32'h0100_0000 || w !== 32'h0050_0093 || count !== 16'd1 || err_code !== 2'b01) begin
            tests_failed++; $display("FAIL after_drop: got to=%b addr=%h inst=%h cnt=%0d code=%b, need 01000000 00500093 1 01",
                                     to, a, w, count, err_code);
        end
    endtask

    task automatic test_illegal_fmt();
        bit to;
        pulse_start();
        tests_run++;
        if (err !== 1'b0 || err_code !== 2'b00) begin
            tests_failed++; $display("FAIL start_clears_err: got err=%b code=%b, need 0 00", err, err_code);
        end
        send_req(3'd7, 7'b0110011, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, to);
        send_req(3'd4, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b1, to);
        tests_run++;
        if (to || err !== 1'b1 || err_code !== 2'b10 || count !== 16'd0 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL fmt_drop: got to=%b err=%b code=%b cnt=%0d ov=%b, need 0 1 10 0 0",
                                     to, err, err_code, count, out_valid);
        end
        repeat (2) @(negedge clock);
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++; $display("FAIL illegal_last_done: got done=%b, need 1", done);
        end
    endtask

    task automatic test_restart_flush();
        bit to; logic [31:0] a, w;
        out_ready = 1'b0;
        pulse_start();
        send_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, to);
        send_req(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, to);
        tests_run++;
        if (to || count !== 16'd2 || out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL pre_restart: got to=%b cnt=%0d ov=%b, need 0 2 1", to, count, out_valid);
        end
        in_imm = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
        pulse_start();
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || count !== 16'd0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL restart_flush: got ov=%b cnt=%0d busy=%b, need 0 0 1", out_valid, count, busy);
        end
        send_req(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, to);
        pop_head(a, w, to);
        tests_run++;
        if (to || a !== 32'h0100_0000 || w !== 32'h0050_0093) begin
            tests_failed++; $display("FAIL restart_addr: got to=%b addr=%h inst=%h, need 01000000 00500093", to, a, w);
        end
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_branch_jump();
        test_full_backpressure();
        test_imm_range();
        test_illegal_fmt();
        test_restart_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
